max_pooling_layer_1: RTL and testbench

- Downstream stage of the first convolutional layer (C1). Consumes its MAPS-wide ReLU output stream, one pixel per map per valid cycle, in raster order over an IN_SIZE x IN_SIZE feature map.
- Performs 2x2 stride-2 signed max pooling per map and emits an (IN_SIZE/2) x (IN_SIZE/2) stream in the same packed format for the next convolutional layer.
- Buffering is one half-row of partial maxima per map, so no full-frame storage is needed.

---
 rtl/max_pooling_layer_1_pkg.sv | 17 +
 rtl/max_pooling_layer_1_pool_unit.sv | 72 +++++++
 rtl/max_pooling_layer_1.sv | 90 +++++++++
 tb/tb_max_pooling_layer_1.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pooling_layer_1_pkg.sv
// Shared geometry, default widths and signed max helper for the pooling layers.
// Pure declarations; no latency or flow control of its own.
package max_pooling_layer_1_pkg;

    localparam int C1_OUT_SIZE   = 28;
    localparam int S2_OUT_SIZE   = 14;
    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_MAPS      = 6;
    localparam int MAX_W         = 64;

    // Callers sign-extend narrower feature values to MAX_W before comparing.
    function automatic logic signed [MAX_W-1:0] max_s(input logic signed [MAX_W-1:0] a,
                                                      input logic signed [MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pooling_layer_1_pool_unit.sv
// One map's 2x2 max pool: hold register, half-row line buffer, result register.
// Result lands one clock after the accepting edge; stalls whenever pix_vld is low.
module max_pooling_layer_1_pool_unit
    import max_pooling_layer_1_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int IN_SIZE   = C1_OUT_SIZE,
    parameter int LBW       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 pix_vld,
    input  logic                 col_odd,
    input  logic                 row_odd,
    input  logic [LBW-1:0]       lb_idx,
    input  logic [BIT_WIDTH-1:0] pixel,
    output logic [BIT_WIDTH-1:0] res
);

    localparam int HALF = IN_SIZE / 2;

    logic [BIT_WIDTH-1:0] hold_q, hold_d;
    logic [BIT_WIDTH-1:0] res_q, res_d;
    logic [BIT_WIDTH-1:0] linebuf_q [HALF];
    logic [BIT_WIDTH-1:0] linebuf_d [HALF];
    logic [BIT_WIDTH-1:0] pair_max;

    function automatic logic [BIT_WIDTH-1:0] smax(input logic [BIT_WIDTH-1:0] a,
                                                  input logic [BIT_WIDTH-1:0] b);
        logic signed [MAX_W-1:0] m;
        m = max_s(MAX_W'($signed(a)), MAX_W'($signed(b)));
        return m[BIT_WIDTH-1:0];
    endfunction

    always_comb begin
        pair_max  = smax(hold_q, pixel);
        hold_d    = hold_q;
        linebuf_d = linebuf_q;
        res_d     = res_q;
        // res is deliberately untouched by clear so a pending output stays visible.
        if (clear) begin
            hold_d = '0;
            for (int i = 0; i < HALF; i++) begin
                linebuf_d[i] = '0;
            end
        end else if (pix_vld) begin
            if (!col_odd) begin
                hold_d = pixel;
            end else if (!row_odd) begin
                linebuf_d[lb_idx] = pair_max;
            end else begin
                res_d = smax(linebuf_q[lb_idx], pair_max);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            res_q     <= '0;
            linebuf_q <= '{default: '0};
        end else begin
            hold_q    <= hold_d;
            res_q     <= res_d;
            linebuf_q <= linebuf_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/max_pooling_layer_1.sv
// 2x2 stride-2 signed max pool over MAPS parallel raster streams from C1.
// Latency 1 clock; no backpressure, in_valid gaps simply freeze all state.
module max_pooling_layer_1
    import max_pooling_layer_1_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int MAPS      = DEF_MAPS,
    parameter int IN_SIZE   = C1_OUT_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [BIT_WIDTH*MAPS-1:0] in,
    input  logic                      in_valid,
    output logic [BIT_WIDTH*MAPS-1:0] out,
    output logic                      out_valid,
    output logic                      frame_done
);

    localparam int CW  = $clog2(IN_SIZE);
    localparam int LBW = (CW > 1) ? CW - 1 : 1;

    logic [CW-1:0]  col_q, col_d;
    logic [CW-1:0]  row_q, row_d;
    logic           out_valid_q, out_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           pix_vld;
    logic           col_last, row_last;
    logic [LBW-1:0] lb_idx;

    // A pixel arriving with clear is dropped rather than counted.
    assign pix_vld  = in_valid & ~clear;
    assign col_last = (col_q == CW'(IN_SIZE - 1));
    assign row_last = (row_q == CW'(IN_SIZE - 1));
    assign lb_idx   = LBW'(col_q >> 1);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = pix_vld & col_q[0] & row_q[0];
        frame_done_d = pix_vld & col_q[0] & row_q[0] & col_last & row_last;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (pix_vld) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar m = 0; m < MAPS; m++) begin : g_map
        max_pooling_layer_1_pool_unit #(
            .BIT_WIDTH (BIT_WIDTH),
            .IN_SIZE   (IN_SIZE),
            .LBW       (LBW)
        ) u_pool (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .pix_vld (pix_vld),
            .col_odd (col_q[0]),
            .row_odd (row_q[0]),
            .lb_idx  (lb_idx),
            .pixel   (in[BIT_WIDTH*m +: BIT_WIDTH]),
            .res     (out[BIT_WIDTH*m +: BIT_WIDTH])
        );
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pooling_layer_1.sv
// Randomised frame stimulus checked against a whole-image 2x2 max reference.
module tb_max_pooling_layer_1;

    localparam int BW   = 32;
    localparam int MAPS = 6;
    localparam int N    = 28;
    localparam int H    = N / 2;

    typedef logic [MAPS*BW-1:0] vec_t;
    typedef struct packed {
        vec_t dat;
        logic fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    vec_t in_dat;
    logic in_valid;
    vec_t out_dat;
    logic out_valid;
    logic frame_done;

    int   tests = 0;
    int   fails = 0;
    int   img [MAPS][N][N];
    exp_t exp_q [$];
    vec_t got_log [$];
    int   fd_cnt = 0;
    vec_t last_out;

    max_pooling_layer_1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in         (in_dat),
        .in_valid   (in_valid),
        .out        (out_dat),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every negedge, outputs must match the reference queue or hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
        end else begin
            if (out_valid) begin
                exp_t e;
                got_log.push_back(out_dat);
                if (frame_done) fd_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_dat);
                end else begin
                    e = exp_q.pop_front();
                    chk("pool_out", out_dat, e.dat);
                    chk("frame_done", vec_t'(frame_done), vec_t'(e.fd));
                end
            end else begin
                chk("frame_done_idle", vec_t'(frame_done), '0);
                chk("out_hold", out_dat, last_out);
            end
            last_out = out_dat;
        end
    end

    task automatic gen_ramp(input int map, input int offset);
        for (int m = 0; m < MAPS; m++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    img[m][r][c] = (m == map) ? r * N + c + offset : 0;
    endtask

    task automatic gen_random();
        for (int m = 0; m < MAPS; m++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    img[m][r][c] = int'($urandom);
    endtask

    // Reference: direct max over each 2x2 block of the stored image.
    task automatic model_frame(input int limit);
        int   cnt;
        int   mx;
        exp_t e;
        cnt = 0;
        for (int pi = 0; pi < H; pi++) begin
            for (int pj = 0; pj < H; pj++) begin
                e.dat = '0;
                for (int m = 0; m < MAPS; m++) begin
                    mx = img[m][2*pi][2*pj];
                    for (int a = 0; a < 2; a++)
                        for (int b = 0; b < 2; b++)
                            if (img[m][2*pi+a][2*pj+b] > mx) mx = img[m][2*pi+a][2*pj+b];
                    e.dat[m*BW +: BW] = mx;
                end
                e.fd = (pi == H - 1) && (pj == H - 1);
                if (cnt < limit) exp_q.push_back(e);
                cnt++;
            end
        end
    endtask

    task automatic drive_pix(input int r, input int c);
        for (int m = 0; m < MAPS; m++) in_dat[m*BW +: BW] = img[m][r][c];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int npix);
        for (int k = 0; k < npix; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            drive_pix(k / N, k % N);
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("drain", vec_t'(exp_q.size()), '0);
    endtask

    task automatic reset_log();
        got_log.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_dat   = '0;
        #3;
        chk("rst_out", out_dat, '0);
        chk("rst_out_valid", vec_t'(out_valid), '0);
        chk("rst_frame_done", vec_t'(frame_done), '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp on map 0, no gaps.
        reset_log();
        gen_ramp(0, 0);
        model_frame(H * H);
        e0 = exp_q[0];
        v  = e0.dat;
        chk("model_first_ramp", vec_t'(v[31:0]), vec_t'(29));
        send_frame(0, N * N);
        drain();
        chk("ramp_count", vec_t'(got_log.size()), vec_t'(196));
        chk("ramp_fd_count", vec_t'(fd_cnt), vec_t'(1));
        if (got_log.size() == 196) begin
            v = got_log[0];
            chk("ramp_first", vec_t'(v[31:0]), vec_t'(29));
            v = got_log[195];
            chk("ramp_last", vec_t'(v[31:0]), vec_t'(783));
        end

        // Signed compare: map 2 holds a negative frame with planted blocks.
        reset_log();
        gen_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[2][r][c] = -100;
        img[2][4][6] = -5;  img[2][4][7] = -3;
        img[2][5][6] = -7;  img[2][5][7] = -9;
        img[2][0][0] = -1;  img[2][0][1] = 3;
        img[2][1][0] = -8;  img[2][1][1] = 2;
        model_frame(H * H);
        send_frame(10, N * N);
        drain();
        chk("sign_count", vec_t'(got_log.size()), vec_t'(196));
        if (got_log.size() == 196) begin
            v = got_log[31];
            chk("sign_neg_block", vec_t'(v[2*BW +: BW]), vec_t'(32'hFFFF_FFFD));
            v = got_log[0];
            chk("sign_mixed_block", vec_t'(v[2*BW +: BW]), vec_t'(3));
            v = got_log[1];
            chk("sign_bg_block", vec_t'(v[2*BW +: BW]), vec_t'(32'hFFFF_FF9C));
        end

        // Ramp on map 1 with in_valid low about half the time.
        reset_log();
        gen_ramp(1, 0);
        model_frame(H * H);
        send_frame(50, N * N);
        drain();
        chk("gap_count", vec_t'(got_log.size()), vec_t'(196));
        if (got_log.size() == 196) begin
            v = got_log[0];
            chk("gap_first", vec_t'(v[63:32]), vec_t'(29));
            v = got_log[195];
            chk("gap_last", vec_t'(v[63:32]), vec_t'(783));
        end

        // Two frames back to back, second offset by 1000.
        reset_log();
        gen_ramp(0, 0);
        model_frame(H * H);
        send_frame(0, N * N);
        gen_ramp(0, 1000);
        model_frame(H * H);
        send_frame(0, N * N);
        drain();
        chk("b2b_count", vec_t'(got_log.size()), vec_t'(392));
        chk("b2b_fd_count", vec_t'(fd_cnt), vec_t'(2));
        if (got_log.size() == 392) begin
            v = got_log[196];
            chk("b2b_second_first", vec_t'(v[31:0]), vec_t'(1029));
        end

        // Clear at (10,5) during a random frame, then a fresh negative frame.
        reset_log();
        gen_random();
        model_frame(70);
        send_frame(20, 10 * N + 5);
        for (int m = 0; m < MAPS; m++) in_dat[m*BW +: BW] = img[m][10][5];
        clear    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int m = 0; m < MAPS; m++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    img[m][r][c] = -(r * N + c) - 5000 * (m + 1);
        model_frame(H * H);
        send_frame(0, N * N);
        drain();
        chk("clear_count", vec_t'(got_log.size()), vec_t'(70 + 196));
        chk("clear_fd_count", vec_t'(fd_cnt), vec_t'(1));

        // Asynchronous reset while out_valid is high.
        reset_log();
        gen_ramp(0, 0);
        send_frame(0, N + 2);
        chk("arst_pre_valid", vec_t'(out_valid), vec_t'(1));
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out", out_dat, '0);
        chk("arst_out_valid", vec_t'(out_valid), '0);
        chk("arst_frame_done", vec_t'(frame_done), '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_log();
        gen_ramp(3, 7);
        model_frame(H * H);
        send_frame(25, N * N);
        drain();
        chk("arst_resume_count", vec_t'(got_log.size()), vec_t'(196));
        chk("arst_resume_fd", vec_t'(fd_cnt), vec_t'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
